// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg: shared types and constants for the writeback arbiter.
//   wb_entry_t : one queued FPU result {live, float bank, dest index, data}
//   wb_tag_t   : destination-only view of an entry, used for hazard lookup
//   ZERO_REG   : hard-wired zero register index ($zero / $fzero)
// The queue entry width is fixed by WB_ADDR_W/WB_DATA_W; the arbiter's
// ADDR_W/DATA_W parameters are expected to match these.
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam int unsigned WB_ADDR_W = 5;
   localparam int unsigned WB_DATA_W = 32;

   localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic                 live;
      logic                 float;
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   typedef struct packed {
      logic                 float;
      logic [WB_ADDR_W-1:0] rd;
   } wb_tag_t;

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo: in-order circular buffer of FPU results with per-entry kill.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_push      : append i_entry at the tail (caller guarantees not full)
//   i_entry     : entry to append
//   i_pop       : consume the head (caller guarantees not empty)
//   i_kill      : per-slot live-bit clear
//   o_head      : entry at the head
//   o_count     : occupancy, killed entries included
//   o_live      : per-slot live bits (popped/empty slots read 0)
//   o_tags      : per-slot destination tags
// ----------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  wb_entry_t             i_entry,
   input  logic                  i_pop,
   input  logic [DEPTH-1:0]      i_kill,
   output wb_entry_t             o_head,
   output logic [CNT_W-1:0]      o_count,
   output logic [DEPTH-1:0]      o_live,
   output wb_tag_t [DEPTH-1:0]   o_tags
);

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;

   // Storage and pointers; a push overrides a kill on the same slot, and
   // popping clears live so vacated slots never report a hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_kill[i]) r_mem[i].live <= 1'b0;
         end
         if (i_pop) begin
            r_mem[r_head].live <= 1'b0;
            r_head             <= r_head + PTR_W'(1);
         end
         if (i_push) begin
            r_mem[r_tail] <= i_entry;
            r_tail        <= r_tail + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   // Parallel entry view
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         o_live[i]       = r_mem[i].live;
         o_tags[i].float = r_mem[i].float;
         o_tags[i].rd    = r_mem[i].rd;
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter: owns the register file write port. ALU results always
// win and never stall; FPU results queue in wb_fifo while the port is busy.
// Writes to index 0 are dropped; ALU writes kill older queued FPU writes to
// the same register.
// Optional build macro: WB_BYPASS_EN -- when idle and the queue is empty an
// FPU result goes straight to the port (1-cycle latency) instead of queuing.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   int_valid/int_reg/int_float/int_data: ALU result (always accepted)
//   fpu_valid/fpu_ready/fpu_reg/...     : FPU result, valid/ready handshake
//   writeReg/writeData/regWrite/float   : registered register-file write
//   chk_reg/chk_float/chk_hit           : pending-write lookup (comb)
//   q_count                             : queue occupancy
// ----------------------------------------------------------------------------
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned ADDR_W = WB_ADDR_W,
   parameter  int unsigned DATA_W = WB_DATA_W,
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              int_valid,
   input  logic [ADDR_W-1:0] int_reg,
   input  logic              int_float,
   input  logic [DATA_W-1:0] int_data,
   input  logic              fpu_valid,
   output logic              fpu_ready,
   input  logic [ADDR_W-1:0] fpu_reg,
   input  logic              fpu_float,
   input  logic [DATA_W-1:0] fpu_data,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              regWrite,
   output logic              float,
   input  logic [ADDR_W-1:0] chk_reg,
   input  logic              chk_float,
   output logic              chk_hit,
   output logic [CNT_W-1:0]  q_count
);

   wb_entry_t             w_head;
   wb_entry_t             w_fpu_entry;
   wb_entry_t             w_sel;
   logic                  w_sel_valid;
   logic                  w_bypass;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic [DEPTH-1:0]      w_kill;
   logic [DEPTH-1:0]      w_live;
   wb_tag_t [DEPTH-1:0]   w_tags;
   logic [CNT_W-1:0]      w_count;

   assign w_fpu_entry.live  = 1'b1;
   assign w_fpu_entry.float = fpu_float;
   assign w_fpu_entry.rd    = WB_ADDR_W'(fpu_reg);
   assign w_fpu_entry.data  = WB_DATA_W'(fpu_data);

   // Ready depends on the count only, so a full queue refuses even on a pop.
   assign w_empty   = (w_count == '0);
   assign fpu_ready = (w_count != CNT_W'(DEPTH));
   assign q_count   = w_count;

   // Port selection: ALU, else queue head, else (optionally) direct FPU.
   always_comb begin
      w_sel       = '0;
      w_sel_valid = 1'b0;
      w_bypass    = 1'b0;
      if (int_valid) begin
         w_sel.live  = 1'b1;
         w_sel.float = int_float;
         w_sel.rd    = WB_ADDR_W'(int_reg);
         w_sel.data  = WB_DATA_W'(int_data);
         w_sel_valid = 1'b1;
      end else if (!w_empty) begin
         w_sel       = w_head;
         w_sel_valid = w_head.live;
`ifdef WB_BYPASS_EN
      end else if (fpu_valid) begin
         w_sel       = w_fpu_entry;
         w_sel_valid = 1'b1;
         w_bypass    = 1'b1;
`endif
      end
   end

   assign w_pop  = !int_valid && !w_empty;
   assign w_push = fpu_valid && fpu_ready && !w_bypass;

   // WAW kill against older queued writes; lookup ignores the zero register.
   always_comb begin
      w_kill  = '0;
      chk_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_kill[i] = int_valid && w_live[i] &&
                     (w_tags[i].rd == WB_ADDR_W'(int_reg)) &&
                     (w_tags[i].float == int_float);
         if (w_live[i] && (w_tags[i].rd == WB_ADDR_W'(chk_reg)) &&
             (w_tags[i].float == chk_float) &&
             (WB_ADDR_W'(chk_reg) != ZERO_REG)) begin
            chk_hit = 1'b1;
         end
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_entry (w_fpu_entry),
      .i_pop   (w_pop),
      .i_kill  (w_kill),
      .o_head  (w_head),
      .o_count (w_count),
      .o_live  (w_live),
      .o_tags  (w_tags)
   );

   // Registered register-file write; index 0 is consumed without writing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
         float     <= 1'b0;
      end else begin
         regWrite <= w_sel_valid && (w_sel.rd != ZERO_REG);
         if (w_sel_valid) begin
            writeReg  <= ADDR_W'(w_sel.rd);
            writeData <= DATA_W'(w_sel.data);
            float     <= w_sel.float;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter: directed + pseudo-random stimulus for writeback_arbiter
// with a reference queue model and a scoreboard of expected port writes.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic        live;
      logic        flt;
      logic [4:0]  rd;
      logic [31:0] data;
   } m_t;

   typedef struct {
      logic        flt;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        int_valid;
   logic [4:0]  int_reg;
   logic        int_float;
   logic [31:0] int_data;
   logic        fpu_valid;
   logic        fpu_ready;
   logic [4:0]  fpu_reg;
   logic        fpu_float;
   logic [31:0] fpu_data;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        regWrite;
   logic        float;
   logic [4:0]  chk_reg;
   logic        chk_float;
   logic        chk_hit;
   logic [2:0]  q_count;

   int   vectors;
   int   miscompares;
   m_t   mq[$];
   exp_t sb[$];

   writeback_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .int_valid (int_valid),
      .int_reg   (int_reg),
      .int_float (int_float),
      .int_data  (int_data),
      .fpu_valid (fpu_valid),
      .fpu_ready (fpu_ready),
      .fpu_reg   (fpu_reg),
      .fpu_float (fpu_float),
      .fpu_data  (fpu_data),
      .writeReg  (writeReg),
      .writeData (writeData),
      .regWrite  (regWrite),
      .float     (float),
      .chk_reg   (chk_reg),
      .chk_float (chk_float),
      .chk_hit   (chk_hit),
      .q_count   (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, model the selection for the coming edge,
   // then compare the registered write after that edge.
   task automatic cycle(input logic iv, input logic [4:0] ireg, input logic ifl,
                        input logic [31:0] idat, input logic fv, input logic [4:0] freg,
                        input logic ffl, input logic [31:0] fdat,
                        input logic [4:0] creg, input logic cfl);
      logic ready_m;
      logic hit_m;
      logic byp;
      logic have;
      exp_t e;
      m_t   m;
      int_valid = iv;  int_reg = ireg;  int_float = ifl;  int_data = idat;
      fpu_valid = fv;  fpu_reg = freg;  fpu_float = ffl;  fpu_data = fdat;
      chk_reg   = creg; chk_float = cfl;
      #1;
      ready_m = (mq.size() != DEPTH);
      hit_m   = 1'b0;
      foreach (mq[i])
         if (mq[i].live && mq[i].rd == creg && mq[i].flt == cfl && creg != 5'd0) hit_m = 1'b1;
      check("fpu_ready", 64'(fpu_ready), 64'(ready_m));
      check("chk_hit", 64'(chk_hit), 64'(hit_m));
      have = 1'b0;
      byp  = 1'b0;
      e    = '{flt: 1'b0, rd: 5'd0, data: 32'd0};
      if (iv) begin
         if (ireg != 5'd0) begin
            e = '{flt: ifl, rd: ireg, data: idat};
            have = 1'b1;
         end
         foreach (mq[i])
            if (mq[i].live && mq[i].rd == ireg && mq[i].flt == ifl) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
         m = mq.pop_front();
         if (m.live && m.rd != 5'd0) begin
            e = '{flt: m.flt, rd: m.rd, data: m.data};
            have = 1'b1;
         end
`ifdef WB_BYPASS_EN
      end else if (fv) begin
         byp = 1'b1;
         if (freg != 5'd0) begin
            e = '{flt: ffl, rd: freg, data: fdat};
            have = 1'b1;
         end
`endif
      end
      if (fv && ready_m && !byp) mq.push_back('{live: 1'b1, flt: ffl, rd: freg, data: fdat});
      @(posedge clk);
      if (have) sb.push_back(e);
      @(negedge clk);
      check("q_count", 64'(q_count), 64'(mq.size()));
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("regWrite", 64'(regWrite), 64'd1);
         check("writeReg", 64'(writeReg), 64'(e.rd));
         check("writeData", 64'(writeData), 64'(e.data));
         check("float", 64'(float), 64'(e.flt));
      end else begin
         check("regWrite_idle", 64'(regWrite), 64'd0);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      vectors = 0;  miscompares = 0;
      rst_n = 1'b0;
      int_valid = 0; int_reg = 0; int_float = 0; int_data = 0;
      fpu_valid = 0; fpu_reg = 0; fpu_float = 0; fpu_data = 0;
      chk_reg = 0; chk_float = 0;
      #1;
      check("rst_regWrite", 64'(regWrite), 64'd0);
      check("rst_writeReg", 64'(writeReg), 64'd0);
      check("rst_writeData", 64'(writeData), 64'd0);
      check("rst_float", 64'(float), 64'd0);
      check("rst_q_count", 64'(q_count), 64'd0);
      check("rst_fpu_ready", 64'(fpu_ready), 64'd1);
      check("rst_chk_hit", 64'(chk_hit), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU only: reg 1 <= 44
      cycle(1, 5'd1, 0, 32'd44, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Starvation: ALU every cycle while FPU offers 5 results
      for (int k = 0; k < 5; k++)
         cycle(1, 5'(3 + k), 0, 32'(100 + k), 1, 5'(8 + k), 1, 32'(32'hA000 + k), 0, 0);
      check("starve_count", 64'(q_count), 64'd4);
      check("starve_ready", 64'(fpu_ready), 64'd0);
      idle(5);

      // WAW kill of queued float reg 2
      cycle(1, 5'd9, 0, 32'd9, 1, 5'd2, 1, 32'hF0F0F0F0, 5'd2, 1);
      cycle(1, 5'd2, 1, 32'h33333333, 0, 0, 0, 0, 5'd2, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd2, 1);
      idle(1);

      // Zero drop in both banks
      cycle(1, 5'd0, 0, 32'hFFFFFFFF, 1, 5'd0, 1, 32'hFFFFFFFF, 0, 0);
      idle(2);
      check("zero_q_empty", 64'(q_count), 64'd0);

      // FPU from idle (bypass or queued latency)
      cycle(0, 0, 0, 0, 1, 5'd31, 0, 32'h33333333, 0, 0);
      idle(2);

      // Pseudo-random mix on a few registers to exercise kills and lookup
      for (int k = 0; k < 60; k++)
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      idle(6);

      // Reset mid-drain with 3 entries queued
      for (int k = 0; k < 3; k++)
         cycle(1, 5'd10, 0, 32'd10, 1, 5'(11 + k), 1, 32'(32'hB000 + k), 0, 0);
      check("pre_rst_count", 64'(q_count), 64'd3);
      int_valid = 0; fpu_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_regWrite", 64'(regWrite), 64'd0);
      check("mid_rst_q_count", 64'(q_count), 64'd0);
      check("mid_rst_fpu_ready", 64'(fpu_ready), 64'd1);
      check("mid_rst_chk_hit", 64'(chk_hit), 64'd0);
      mq.delete();
      sb.delete();
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_regWrite", 64'(regWrite), 64'd0);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that owns the single write port of `registerFile`. It merges two producers: the single-cycle integer/ALU path, which never stalls, and the multi-cycle FPU path, which uses a valid/ready handshake. FPU results are buffered in a small in-order queue whenever the port is busy. The block drives `registerFile`'s `writeReg`/`writeData`/`regWrite`/`float` inputs directly and exposes a pending-write lookup for the hazard unit.

## Interface
- `DEPTH`, 4 — FPU result queue entries, power of two, ≥2
- `ADDR_W`, 5 — register index width
- `DATA_W`, 32 — register data width
- `clk`  in  1  clock, shared with `registerFile`
- `rst_n`  in  1  asynchronous, active-low reset
- `int_valid`  in  1  ALU result present this cycle; always accepted
- `int_reg`  in  ADDR_W  ALU destination index
- `int_float`  in  1  ALU destination bank, 1 = float
- `int_data`  in  DATA_W  ALU result
- `fpu_valid`  in  1  FPU result offered
- `fpu_ready`  out  1  queue can accept an FPU result
- `fpu_reg`  in  ADDR_W  FPU destination index
- `fpu_float`  in  1  FPU destination bank
- `fpu_data`  in  DATA_W  FPU result
- `writeReg`  out  ADDR_W  to `registerFile`
- `writeData`  out  DATA_W  to `registerFile`
- `regWrite`  out  1  to `registerFile`
- `float`  out  1  to `registerFile`
- `chk_reg`  in  ADDR_W  hazard-lookup index
- `chk_float`  in  1  hazard-lookup bank
- `chk_hit`  out  1  a live queued write targets (`chk_reg`, `chk_float`)
- `q_count`  out  $clog2(DEPTH)+1  queue occupancy, including killed entries

## Operation
- Push: when `fpu_valid && fpu_ready`, the entry {reg, float, data, live=1} is appended at the tail.
- `fpu_ready` = (`q_count` != DEPTH). It is combinational from the count only. When the queue is full, a push is refused even if a pop happens in the same cycle.
- Port selection, evaluated each cycle:
  - If `int_valid`: the ALU result is selected.
  - Otherwise, if the queue is non-empty: pop the head. It is selected if live. A killed entry is consumed with no write.
  - Otherwise: bypass (see Configuration), or no write.
- Zero drop: a selected write with index 0 in either bank ($zero or $fzero) produces `regWrite`=0. The queue entry is still consumed.
- WAW kill: every live queue entry matching (`int_reg`, `int_float`) has its `live` bit cleared in the cycle `int_valid` is high. Upstream guarantees that queued FPU results are always older in program order than a concurrent ALU result.
- Entries pushed in the same cycle as a matching `int_valid` are not killed.
- `chk_hit`: combinational OR over live entries of (reg==`chk_reg` && float==`chk_float`). Index 0 never hits.
- Queue pointers wrap modulo DEPTH.

## Timing
- All `registerFile`-side outputs are registered. A selection at edge N appears in the cycle after N, and the register file commits at edge N+1.
- ALU latency is 1 cycle. Queued FPU latency is ≥2 cycles: push at edge N, earliest output after edge N+1.
- Continuous `int_valid` starves the queue. After DEPTH pushes, `fpu_ready` falls, and it rises the cycle after the first pop.
- Reset (asynchronous, any time):
  - `regWrite`=0, `writeReg`=0, `writeData`=0, `float`=0.
  - Queue emptied, `q_count`=0, `fpu_ready`=1, `chk_hit`=0.
  - In-flight results are discarded. Inputs are ignored while `rst_n`=0.

## Configuration
- `WB_BYPASS_EN` defined: when the queue is empty and `int_valid`=0, an accepted FPU result is selected directly. It is not pushed, and its latency is 1 cycle.
- `WB_BYPASS_EN` undefined: every FPU result goes through the queue.
- `fpu_ready` and kill rules are identical in both builds.

## Structure
- Package `wb_pkg` holds:
  - `wb_entry_t`, a packed struct {`live`, `float`, `reg` [ADDR_W], `data` [DATA_W]}
  - default `ADDR_W`/`DATA_W` constants
  - `ZERO_REG` = 0
- Sub-module `wb_fifo`: circular buffer of `wb_entry_t` with push/pop, count, a per-entry kill vector input and a parallel entry view for `chk_hit`.
- Arbitration, zero drop and output registers live in `writeback_arbiter`.

## Test plan
- **ALU only:** `int_valid` with reg 1, data 44 → next cycle `regWrite`=1, `writeReg`=1, `writeData`=0x2C, `float`=0.
- **Starvation:** `int_valid` held high while FPU pushes 5 results → `fpu_ready`=0 after 4 pushes and `q_count`=4. Release `int_valid` → the 4 results drain in order, one per cycle.
- **WAW kill:** queue float reg 2 = 0xF0F0F0F0, then `int_valid` float reg 2 = 0x33333333 → only 0x33333333 is written. The killed entry pops with `regWrite`=0, and `chk_hit` for (2, float) drops to 0.
- **Zero drop:** FPU writes 0xFFFFFFFF to float reg 0 and ALU writes it to int reg 0 → `regWrite` stays 0 and `q_count` returns to 0.
- **Bypass:** idle, FPU result for reg 31 = 0x33333333 → output after 1 cycle with `WB_BYPASS_EN`, after 2 cycles without.
- **Reset mid-drain:** 3 entries queued, `rst_n` pulsed low between edges → `regWrite`=0 immediately, `q_count`=0, `fpu_ready`=1, and no further writes after release.
